// File: rtl/mem_access_unit.sv
// Multicycle load/store stage: req/ack access to a 64-bit word memory, sub-word stores by RMW.
// Optional ack timeout is enabled by defining MEMACC_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [63:0] rdata,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {StIdle, StCheck, StRead, StMerge, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        fault_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;

  logic [63:0] size_mask;
  logic [63:0] lane_mask;
  logic [63:0] merged;
  logic [63:0] load_data;
  logic        misaligned;
  logic        invalid;
  logic        is_sd;
  logic        timeout;

  always_comb begin
    size_mask  = '1;
    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b00: size_mask = 64'h0000_0000_0000_00ff;
      2'b01: begin
        size_mask  = 64'h0000_0000_0000_ffff;
        misaligned = off_q[0];
      end
      2'b10: begin
        size_mask  = 64'h0000_0000_ffff_ffff;
        misaligned = |off_q[1:0];
      end
      default: misaligned = |off_q;
    endcase
  end

  assign invalid   = (funct3_q == 3'b111) || (is_store_q && funct3_q[2]);
  assign is_sd     = is_store_q && (funct3_q == 3'b011);
  assign lane_mask = size_mask << {off_q, 3'b000};
  assign merged    = (mem_wdata_q & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
  assign load_data = (mem_rdata >> {off_q, 3'b000}) & size_mask;

`ifdef MEMACC_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  logic [TmoW-1:0] tmo_cnt_q;

  // Counter is held at zero outside the wait states, so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (reset || !(state_q inside {StRead, StWrite})) begin
      tmo_cnt_q <= '0;
    end else if (!mem_ack) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q inside {StRead, StWrite}) && !mem_ack &&
                   (tmo_cnt_q == TmoW'(ACK_TIMEOUT - 1));
`else
  // Without the counter the parameter has no effect.
  assign timeout = 1'b0 & (ACK_TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StCheck;
      StCheck: begin
        if (misaligned || invalid) state_d = StDone;
        else if (is_sd)            state_d = StWrite;
        else                       state_d = StRead;
      end
      StRead: begin
        if (mem_ack)      state_d = is_store_q ? StMerge : StDone;
        else if (timeout) state_d = StDone;
      end
      StMerge: state_d = StWrite;
      StWrite: if (mem_ack || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: if (start) begin
          is_store_q <= is_store;
          funct3_q   <= funct3;
          off_q      <= addr[2:0];
          wdata_q    <= wdata;
          mem_addr_q <= {addr[63:3], 3'b000};
          fault_q    <= 1'b0;
        end
        StCheck: begin
          if (misaligned || invalid) fault_q     <= 1'b1;
          else if (is_sd)            mem_wdata_q <= wdata_q;
        end
        StRead: begin
          if (mem_ack) begin
            if (is_store_q) mem_wdata_q <= mem_rdata;
            else            rdata_q     <= load_data;
          end else if (timeout) begin
            fault_q <= 1'b1;
          end
        end
        StMerge: mem_wdata_q <= merged;
        StWrite: if (!mem_ack && timeout) fault_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign mem_req   = (state_q == StRead) || (state_q == StWrite);
  assign mem_we    = (state_q == StWrite);
  assign rdata     = rdata_q;
  assign fault     = fault_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random loads/stores against a
// byte-level reference model and a behavioural ack-latency memory.
module tb_mem_access_unit;

`ifdef MEMACC_TIMEOUT_EN
  localparam int unsigned Tmo = 4;
`else
  localparam int unsigned Tmo = 16;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        busy, done, fault, mem_req, mem_we;
  logic [63:0] rdata, mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  // Memory model state: bench sets rd_word/lat, model records accesses.
  logic [63:0] rd_word = '0;
  int          lat = 1;
  int          wait_cnt = 0;
  int          rd_cnt = 0, wr_cnt = 0, req_cycles = 0, we_cycles = 0;
  logic [63:0] wr_word = '0, wr_addr = '0, rd_addr = '0;

  int          n_checks = 0, n_errors = 0;
  logic [63:0] exp_rdata = '0;

  mem_access_unit #(.ACK_TIMEOUT(Tmo)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) begin
      if (wait_cnt + 1 >= lat) begin
        mem_ack  <= 1'b1;
        wait_cnt <= 0;
        if (mem_we) begin
          wr_word <= mem_wdata;
          wr_addr <= mem_addr;
          wr_cnt  <= wr_cnt + 1;
          mem_rdata <= {$urandom, $urandom};
        end else begin
          mem_rdata <= rd_word;
          rd_addr   <= mem_addr;
          rd_cnt    <= rd_cnt + 1;
        end
      end else begin
        wait_cnt  <= wait_cnt + 1;
        mem_rdata <= {$urandom, $urandom};
      end
    end else begin
      mem_ack   <= 1'b0;
      mem_rdata <= {$urandom, $urandom};
      if (!mem_req) wait_cnt <= 0;
    end
    if (mem_req)           req_cycles <= req_cycles + 1;
    if (mem_req && mem_we) we_cycles  <= we_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_fault(input logic st, input logic [2:0] f3, input logic [2:0] off);
    if (f3 == 3'b111) return 1'b1;
    if (st && f3[2]) return 1'b1;
    return (int'(off) % size_of(f3)) != 0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [2:0] f3,
                                           input logic [2:0] off);
    logic [63:0] r = '0;
    for (int i = 0; i < size_of(f3); i++) r[8*i +: 8] = word[8*(int'(off)+i) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_store(input logic [63:0] word, input logic [63:0] wd,
                                            input logic [2:0] f3, input logic [2:0] off);
    logic [63:0] r = word;
    for (int i = 0; i < size_of(f3); i++) r[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Issues one request and returns at the negedge of the done cycle; cyc = cycles after start.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] word, input int l,
                         output int cyc);
    rd_word = word;
    lat     = l;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    cyc = 1;
    check("busy_after_start", busy, 1'b1);
    // A stray start while busy with different operands must be ignored.
    start = 1'($urandom_range(0, 1));
    is_store = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    while (!done && cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    int          cyc;
    int          rd0, wr0, rq0, we0;
    logic        r_st, r_f;
    logic [2:0]  r_f3, amask;
    logic [63:0] r_addr, r_wd, r_word;
    int          r_lat;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    reset = 1'b0;

    // lw
    run_txn(1'b0, 3'b010, 64'h1004, 64'h0, 64'h89AB_CDEF_0123_4567, 1, cyc);
    check("lw_latency", 64'(cyc), 64'd4);
    check("lw_rdata", rdata, 64'h0000_0000_89AB_CDEF);
    check("lw_fault", fault, 1'b0);
    check("lw_mem_addr", rd_addr, 64'h1000);
    // start coinciding with done is dropped
    start = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 64'h0;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", busy, 1'b0);

    // lbu
    we0 = we_cycles;
    run_txn(1'b0, 3'b100, 64'h2007, 64'h0, 64'hF000_0000_0000_0000, 1, cyc);
    check("lbu_rdata", rdata, 64'hF0);
    check("lbu_no_we", 64'(we_cycles - we0), 64'd0);

    // sb
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_txn(1'b1, 3'b000, 64'h3002, 64'hAA, 64'h1122_3344_5566_7788, 1, cyc);
    check("sb_reads", 64'(rd_cnt - rd0), 64'd1);
    check("sb_writes", 64'(wr_cnt - wr0), 64'd1);
    check("sb_wdata", wr_word, 64'h1122_3344_55AA_7788);
    check("sb_wr_addr", wr_addr, 64'h3000);
    check("sb_rdata_kept", rdata, 64'hF0);
    check("sb_fault", fault, 1'b0);

    // sd
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_txn(1'b1, 3'b011, 64'h4000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1, cyc);
    check("sd_latency", 64'(cyc), 64'd4);
    check("sd_reads", 64'(rd_cnt - rd0), 64'd0);
    check("sd_writes", 64'(wr_cnt - wr0), 64'd1);
    check("sd_wdata", wr_word, 64'hDEAD_BEEF_CAFE_F00D);

    // misaligned lh, sw
    rq0 = req_cycles;
    run_txn(1'b0, 3'b001, 64'h5001, 64'h0, 64'h0, 1, cyc);
    check("lh_mis_fault", fault, 1'b1);
    check("lh_mis_latency", 64'(cyc), 64'd2);
    run_txn(1'b1, 3'b010, 64'h5006, 64'h1234, 64'h0, 1, cyc);
    check("sw_mis_fault", fault, 1'b1);
    check("sw_mis_latency", 64'(cyc), 64'd2);
    check("mis_no_req", 64'(req_cycles - rq0), 64'd0);
    check("mis_rdata_kept", rdata, 64'hF0);

    // reset in the middle of a slow load
    rd_word = 64'h5555_AAAA_5555_AAAA;
    lat     = 5;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 64'h6000;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_req", mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_req", mem_req, 1'b0);
    check("mid_reset_done", done, 1'b0);
    exp_rdata = '0;
    run_txn(1'b0, 3'b011, 64'h6008, 64'h0, 64'h0123_4567_89AB_CDEF, 2, cyc);
    check("ld_after_reset_rdata", rdata, 64'h0123_4567_89AB_CDEF);
    check("ld_after_reset_fault", fault, 1'b0);
    check("ld_after_reset_latency", 64'(cyc), 64'd5);
    exp_rdata = 64'h0123_4567_89AB_CDEF;

`ifdef MEMACC_TIMEOUT_EN
    run_txn(1'b0, 3'b011, 64'h7000, 64'h0, 64'h0, 100000, cyc);
    check("tmo_fault", fault, 1'b1);
    check("tmo_latency", 64'(cyc), 64'(2 + Tmo));
    check("tmo_rdata_kept", rdata, exp_rdata);
`endif

    for (int k = 0; k < 60; k++) begin
      r_st   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = {$urandom, $urandom};
      amask  = 3'(size_of(r_f3) - 1);
      if ($urandom_range(0, 3) != 0) r_addr[2:0] = r_addr[2:0] & ~amask;
      r_wd   = {$urandom, $urandom};
      r_word = {$urandom, $urandom};
      r_lat  = $urandom_range(1, 3);
      r_f    = ref_fault(r_st, r_f3, r_addr[2:0]);
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_txn(r_st, r_f3, r_addr, r_wd, r_word, r_lat, cyc);
      check("rnd_fault", fault, r_f);
      if (r_f) begin
        check("rnd_fault_latency", 64'(cyc), 64'd2);
        check("rnd_fault_no_access", 64'((rd_cnt - rd0) + (wr_cnt - wr0)), 64'd0);
      end else if (!r_st) begin
        exp_rdata = ref_load(r_word, r_f3, r_addr[2:0]);
        check("rnd_load_latency", 64'(cyc), 64'(r_lat + 3));
        check("rnd_load_addr", rd_addr, {r_addr[63:3], 3'b000});
      end else begin
        check("rnd_store_reads", 64'(rd_cnt - rd0), (r_f3 == 3'b011) ? 64'd0 : 64'd1);
        check("rnd_store_writes", 64'(wr_cnt - wr0), 64'd1);
        check("rnd_store_addr", wr_addr, {r_addr[63:3], 3'b000});
        check("rnd_store_word", wr_word,
              (r_f3 == 3'b011) ? r_wd : ref_store(r_word, r_wd, r_f3, r_addr[2:0]));
      end
      check("rnd_rdata", rdata, exp_rdata);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
